// File: rtl/scan_scheduler.sv
// Four-digit multiplexed display scanner with a double-buffered display word.
// Optional inter-digit blanking is compiled in with `define DEAD_TIME_EN.
module scan_scheduler #(
   parameter int DIV  = 4,
   parameter int DEAD = 2
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        ENA,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic [1:0]  sel,
   output logic [3:0]  digi,
   output logic [3:0]  nibble,
   output logic        frame_done
);

   // One counter serves both the lit dwell and the blank dwell, so size it for the longer.
   localparam int CNT_MAX = (DIV > DEAD) ? DIV : DEAD;
   localparam int CW      = $clog2(CNT_MAX);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   logic [CW-1:0] presc, presc_nxt;
   logic [1:0]    idx, idx_nxt;
   logic [15:0]   active, pending;
   logic          pending_full;
   logic          boundary;

`ifdef DEAD_TIME_EN
   localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);

   typedef enum logic {SHOW, BLANK} state_t;
   state_t state, state_nxt;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) state <= SHOW;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      presc_nxt = presc;
      idx_nxt   = idx;
      boundary  = 1'b0;
      digi      = 4'b0001 << idx;
      case (state)
         SHOW: begin
            if (ENA) begin
               if (presc == DIV_LAST) begin
                  presc_nxt = '0;
                  state_nxt = BLANK;
               end else begin
                  presc_nxt = presc + CW'(1);
               end
            end
         end
         BLANK: begin
            // sel/nibble keep the finished digit; only the enable is dropped
            digi = 4'b0000;
            if (ENA) begin
               if (presc == DEAD_LAST) begin
                  presc_nxt = '0;
                  state_nxt = SHOW;
                  idx_nxt   = idx + 2'd1;
                  boundary  = (idx == 2'd3);
               end else begin
                  presc_nxt = presc + CW'(1);
               end
            end
         end
         default: state_nxt = SHOW;
      endcase
   end
`else
   always_comb begin
      presc_nxt = presc;
      idx_nxt   = idx;
      boundary  = 1'b0;
      digi      = 4'b0001 << idx;
      if (ENA) begin
         if (presc == DIV_LAST) begin
            presc_nxt = '0;
            idx_nxt   = idx + 2'd1;
            boundary  = (idx == 2'd3);
         end else begin
            presc_nxt = presc + CW'(1);
         end
      end
   end
`endif

   // Boundary swap and a fresh load are exclusive: a full buffer deasserts load_ready.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         presc        <= '0;
         idx          <= 2'd0;
         active       <= 16'h0000;
         pending      <= 16'h0000;
         pending_full <= 1'b0;
      end else begin
         presc <= presc_nxt;
         idx   <= idx_nxt;
         if (boundary && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
         end else if (load_valid && load_ready) begin
            pending      <= load_data;
            pending_full <= 1'b1;
         end
      end
   end

   always_comb begin
      case (idx)
         2'd0:    nibble = active[3:0];
         2'd1:    nibble = active[7:4];
         2'd2:    nibble = active[11:8];
         default: nibble = active[15:12];
      endcase
   end

   assign sel        = {idx[1], idx[1] ^ idx[0]};
   assign load_ready = ~pending_full;
   assign frame_done = boundary;

endmodule
